bomb_game_core: RTL and testbench

Parametrised game controller for the time-bomb design. It holds an N-digit secret code and counts down a BCD min:sec timer driven by the external 1 Hz tick. It checks player guesses with a limited number of attempts and applies a time penalty for each wrong guess. It replaces the fixed 4+3-bit pin and attempt flow with a single configurable FSM that feeds the 7-segment display decoders and the LEDG win indication.

---
 rtl/bomb_game_core.sv | 230 +++++++++++++++++++++++
 tb/tb_bomb_game_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bomb_game_core.sv
// rtl/bomb_game_core.sv - time-bomb game controller: secret code, BCD countdown, guess checking
//
// Ports:
//   Clk, Reset_n      clock, asynchronous active-low reset
//   Tick_1s           one-cycle pulse per second
//   Clear             synchronous return to IDLE (highest priority)
//   Cfg_Load/Cfg_Code latch the secret code (digit 0 in the LSBs)
//   Start             arm the countdown from ARMED
//   Enter/Guess       submit a guess while RUNNING
//   Code_Locked, Running, Game_Won, Time_Over   status flags
//   Attempts_Left     remaining guesses
//   Match_Count       digits in position from the last checked guess
//   Min_Unit, Sec_Tens, Sec_Units               BCD m:ss display
module bomb_game_core #(
    parameter int DIGITS       = 4,
    parameter int DIGIT_W      = 3,
    parameter int MAX_ATTEMPTS = 3,
    parameter int START_MIN    = 5,
    parameter int START_SEC    = 0,
    parameter int PENALTY_SEC  = 10
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            Tick_1s,
    input  logic                            Clear,
    input  logic                            Cfg_Load,
    input  logic [DIGITS*DIGIT_W-1:0]       Cfg_Code,
    input  logic                            Start,
    input  logic                            Enter,
    input  logic [DIGITS*DIGIT_W-1:0]       Guess,
    output logic                            Code_Locked,
    output logic                            Running,
    output logic                            Game_Won,
    output logic                            Time_Over,
    output logic [3:0]                      Attempts_Left,
    output logic [$clog2(DIGITS+1)-1:0]     Match_Count,
    output logic [3:0]                      Min_Unit,
    output logic [3:0]                      Sec_Tens,
    output logic [3:0]                      Sec_Units
);
    localparam int         MW          = $clog2(DIGITS + 1);
    localparam int         CW          = DIGITS * DIGIT_W;
    localparam logic [3:0] MAX_ATT     = 4'(MAX_ATTEMPTS);
    localparam logic [3:0] START_M     = 4'(START_MIN);
    localparam logic [3:0] START_T     = 4'(START_SEC / 10);
    localparam logic [3:0] START_U     = 4'(START_SEC % 10);
    localparam logic [9:0] PEN10       = 10'(PENALTY_SEC);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_RUNNING, S_CHECK, S_WON, S_EXPLODED
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   code_q, code_n;
    logic [CW-1:0]   guess_q, guess_n;
    logic            locked_q, locked_n;
    logic            pend_q, pend_n;
    logic [3:0]      att_q, att_n;
    logic [MW-1:0]   match_q, match_n;
    logic [3:0]      min_q, min_n, tens_q, tens_n, units_q, units_n;

    // One-second BCD decrement, saturating at 0:00.
    logic [3:0] dec_m, dec_t, dec_u;
    logic       dec_zero;
    always_comb begin
        dec_m = min_q;
        dec_t = tens_q;
        dec_u = units_q;
        if (units_q != 4'd0) begin
            dec_u = units_q - 4'd1;
        end else if (tens_q != 4'd0) begin
            dec_u = 4'd9;
            dec_t = tens_q - 4'd1;
        end else if (min_q != 4'd0) begin
            dec_u = 4'd9;
            dec_t = 4'd5;
            dec_m = min_q - 4'd1;
        end
        dec_zero = (dec_m == 4'd0) && (dec_t == 4'd0) && (dec_u == 4'd0);
    end

    // Penalty goes through binary seconds so the borrow chain stays trivial.
    logic [9:0] total_sec, pen_sec, pen_rem;
    logic [3:0] pen_m, pen_t, pen_u;
    logic       pen_zero;
    always_comb begin
        total_sec = {6'd0, min_q} * 10'd60 + {6'd0, tens_q} * 10'd10 + {6'd0, units_q};
        pen_sec   = (total_sec > PEN10) ? (total_sec - PEN10) : 10'd0;
        pen_rem   = pen_sec % 10'd60;
        pen_m     = 4'(pen_sec / 10'd60);
        pen_t     = 4'(pen_rem / 10'd10);
        pen_u     = 4'(pen_rem % 10'd10);
        pen_zero  = (pen_sec == 10'd0);
    end

    logic [MW-1:0] match_cnt;
    always_comb begin
        match_cnt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (guess_q[i*DIGIT_W +: DIGIT_W] == code_q[i*DIGIT_W +: DIGIT_W])
                match_cnt = match_cnt + MW'(1);
        end
    end

    always_comb begin
        state_n  = state;
        code_n   = code_q;
        guess_n  = guess_q;
        locked_n = locked_q;
        pend_n   = pend_q;
        att_n    = att_q;
        match_n  = match_q;
        min_n    = min_q;
        tens_n   = tens_q;
        units_n  = units_q;

        if (Clear) begin
            state_n  = S_IDLE;
            code_n   = '0;
            guess_n  = '0;
            locked_n = 1'b0;
            pend_n   = 1'b0;
            att_n    = MAX_ATT;
            match_n  = '0;
            min_n    = START_M;
            tens_n   = START_T;
            units_n  = START_U;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Cfg_Load) begin
                        code_n   = Cfg_Code;
                        locked_n = 1'b1;
                        state_n  = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (Cfg_Load)
                        code_n = Cfg_Code;
                    if (Start) begin
                        min_n   = START_M;
                        tens_n  = START_T;
                        units_n = START_U;
                        att_n   = MAX_ATT;
                        pend_n  = 1'b0;
                        state_n = S_RUNNING;
                    end
                end
                S_RUNNING: begin
                    // A tick held over from CHECK is applied here; a second
                    // tick arriving in the same cycle stays pending.
                    pend_n = Tick_1s & pend_q;
                    if (Tick_1s || pend_q) begin
                        min_n   = dec_m;
                        tens_n  = dec_t;
                        units_n = dec_u;
                    end
                    if ((Tick_1s || pend_q) && dec_zero) begin
                        pend_n  = 1'b0;
                        state_n = S_EXPLODED;
                    end else if (Enter) begin
                        guess_n = Guess;
                        state_n = S_CHECK;
                    end
                end
                S_CHECK: begin
                    match_n = match_cnt;
                    pend_n  = pend_q | Tick_1s;
                    if (match_cnt == MW'(DIGITS)) begin
                        pend_n  = 1'b0;
                        state_n = S_WON;
                    end else begin
                        att_n = att_q - 4'd1;
                        if (att_q <= 4'd1 || pen_zero) begin
                            pend_n  = 1'b0;
                            min_n   = 4'd0;
                            tens_n  = 4'd0;
                            units_n = 4'd0;
                            state_n = S_EXPLODED;
                        end else begin
                            min_n   = pen_m;
                            tens_n  = pen_t;
                            units_n = pen_u;
                            state_n = S_RUNNING;
                        end
                    end
                end
                default: begin
                    // WON and EXPLODED hold until Clear or reset.
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            code_q   <= '0;
            guess_q  <= '0;
            locked_q <= 1'b0;
            pend_q   <= 1'b0;
            att_q    <= MAX_ATT;
            match_q  <= '0;
            min_q    <= START_M;
            tens_q   <= START_T;
            units_q  <= START_U;
        end else begin
            state    <= state_n;
            code_q   <= code_n;
            guess_q  <= guess_n;
            locked_q <= locked_n;
            pend_q   <= pend_n;
            att_q    <= att_n;
            match_q  <= match_n;
            min_q    <= min_n;
            tens_q   <= tens_n;
            units_q  <= units_n;
        end
    end

    assign Code_Locked   = locked_q;
    assign Running       = (state == S_RUNNING) || (state == S_CHECK);
    assign Game_Won      = (state == S_WON);
    assign Time_Over     = (state == S_EXPLODED);
    assign Attempts_Left = att_q;
    assign Match_Count   = match_q;
    assign Min_Unit      = min_q;
    assign Sec_Tens      = tens_q;
    assign Sec_Units     = units_q;
endmodule

// File: tb/tb_bomb_game_core.sv
// tb/tb_bomb_game_core.sv - directed self-checking bench for bomb_game_core
module tb_bomb_game_core;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Tick_1s = 1'b0;
    logic        Clear = 1'b0;
    logic        Cfg_Load = 1'b0;
    logic [11:0] Cfg_Code = '0;
    logic        Start = 1'b0;
    logic        Enter = 1'b0;
    logic [11:0] Guess = '0;
    logic        Code_Locked, Running, Game_Won, Time_Over;
    logic [3:0]  Attempts_Left;
    logic [2:0]  Match_Count;
    logic [3:0]  Min_Unit, Sec_Tens, Sec_Units;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] CODE    = 12'h5A3;  // digits 3,4,6,2 from LSB
    localparam logic [11:0] TWO_HIT = 12'h023;  // digits 3,4,0,0: two match
    localparam logic [11:0] NO_HIT  = 12'h000;  // no digit matches

    bomb_game_core dut (
        .Clk(Clk), .Reset_n(Reset_n), .Tick_1s(Tick_1s), .Clear(Clear),
        .Cfg_Load(Cfg_Load), .Cfg_Code(Cfg_Code), .Start(Start),
        .Enter(Enter), .Guess(Guess), .Code_Locked(Code_Locked),
        .Running(Running), .Game_Won(Game_Won), .Time_Over(Time_Over),
        .Attempts_Left(Attempts_Left), .Match_Count(Match_Count),
        .Min_Unit(Min_Unit), .Sec_Tens(Sec_Tens), .Sec_Units(Sec_Units)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] timer();
        return {20'd0, Min_Unit, Sec_Tens, Sec_Units};
    endfunction

    // Advance one active edge, then drop all pulses 1 time unit later.
    task automatic clk1();
        @(posedge Clk);
        #1;
        Tick_1s  = 1'b0;
        Enter    = 1'b0;
        Start    = 1'b0;
        Cfg_Load = 1'b0;
        Clear    = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            Tick_1s = 1'b1;
            clk1();
            clk1();
        end
    endtask

    task automatic load_start();
        Cfg_Code = CODE;
        Cfg_Load = 1'b1;
        clk1();
        Start = 1'b1;
        clk1();
    endtask

    task automatic enter_guess(input logic [11:0] g);
        Guess = g;
        Enter = 1'b1;
        clk1();
        clk1();
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        clk1();
    endtask

    initial begin
        clk1();
        clk1();
        chk("rst_timer", timer(), 32'h500);
        chk("rst_att", Attempts_Left, 3);
        chk("rst_flags", {Code_Locked, Running, Game_Won, Time_Over}, 0);
        chk("rst_match", Match_Count, 0);
        Reset_n = 1'b1;

        // Async reset in the middle of a countdown
        Cfg_Code = CODE;
        Cfg_Load = 1'b1;
        clk1();
        chk("locked", Code_Locked, 1);
        chk("armed_not_run", Running, 0);
        Start = 1'b1;
        clk1();
        chk("running", Running, 1);
        ticks(93);
        chk("t_327", timer(), 32'h327);
        Reset_n = 1'b0;
        clk1();
        chk("mid_rst_timer", timer(), 32'h500);
        chk("mid_rst_att", Attempts_Left, 3);
        chk("mid_rst_flags", {Code_Locked, Running, Game_Won, Time_Over}, 0);
        Reset_n = 1'b1;
        clk1();

        // Correct guess freezes the timer
        load_start();
        ticks(3);
        chk("t_457", timer(), 32'h457);
        enter_guess(CODE);
        chk("win_match", Match_Count, 4);
        chk("win_flag", Game_Won, 1);
        chk("win_norun", Running, 0);
        chk("win_att", Attempts_Left, 3);
        ticks(2);
        chk("win_frozen", timer(), 32'h457);
        do_clear();

        // Start ignored in IDLE
        Start = 1'b1;
        clk1();
        chk("idle_start", Running, 0);

        // Penalty saturates at 0:00
        load_start();
        ticks(295);
        chk("t_005", timer(), 32'h005);
        enter_guess(TWO_HIT);
        chk("sat_match", Match_Count, 2);
        chk("sat_att", Attempts_Left, 2);
        chk("sat_timer", timer(), 32'h000);
        chk("sat_over", Time_Over, 1);
        do_clear();

        // Three wrong guesses
        load_start();
        ticks(10);
        chk("t_450", timer(), 32'h450);
        enter_guess(NO_HIT);
        chk("w1_timer", timer(), 32'h440);
        chk("w1_att", Attempts_Left, 2);
        chk("w1_match", Match_Count, 0);
        chk("w1_run", Running, 1);
        enter_guess(NO_HIT);
        chk("w2_timer", timer(), 32'h430);
        chk("w2_att", Attempts_Left, 1);
        enter_guess(NO_HIT);
        chk("w3_over", Time_Over, 1);
        chk("w3_att", Attempts_Left, 0);
        chk("w3_timer", timer(), 32'h000);
        do_clear();

        // Tick coincident with Enter, tick during CHECK
        load_start();
        ticks(240);
        chk("t_100", timer(), 32'h100);
        Tick_1s = 1'b1;
        Enter   = 1'b1;
        Guess   = TWO_HIT;
        clk1();
        chk("co_059", timer(), 32'h059);
        Tick_1s = 1'b1;
        clk1();
        chk("co_049", timer(), 32'h049);
        chk("co_att", Attempts_Left, 2);
        clk1();
        chk("pend_048", timer(), 32'h048);
        chk("pend_run", Running, 1);

        // Final tick with a coincident correct guess: explosion wins
        ticks(47);
        chk("t_001", timer(), 32'h001);
        chk("t_001_alive", Time_Over, 0);
        Tick_1s = 1'b1;
        Enter   = 1'b1;
        Guess   = CODE;
        clk1();
        chk("boom_timer", timer(), 32'h000);
        chk("boom_over", Time_Over, 1);
        clk1();
        chk("boom_nowin", Game_Won, 0);
        chk("boom_match", Match_Count, 2);
        enter_guess(CODE);
        chk("exp_enter_ign", {Game_Won, Time_Over}, 1);
        chk("exp_enter_match", Match_Count, 2);
        do_clear();
        chk("clr_locked", Code_Locked, 0);
        chk("clr_over", Time_Over, 0);
        chk("clr_att", Attempts_Left, 3);
        chk("clr_timer", timer(), 32'h500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
